// File: rtl/tx_packet_ctrl.sv
// USB full-speed transmit sequencer: bit timing, SYNC/PID/DATA serialisation,
// bit stuffing, EOP and inter-packet gap. All line outputs are registered.
module tx_packet_ctrl #(
    parameter int CLKS_PER_BIT = 8,
    parameter int IPG_BITS     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       data_pop,
    output logic       tx_bit,
    output logic       tx_se0,
    output logic       tx_oe,
    output logic       bit_strobe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [2:0] dbg_state
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(IPG_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_STUFF, S_EOP_SE0, S_EOP_J, S_IPG
    } state_t;

    state_t        state, state_d, resume, resume_d, bnd_from;
    logic [TW-1:0] timer, timer_d;
    logic [7:0]    sr, sr_d;
    logic [2:0]    idx, idx_d;
    logic [2:0]    ones, ones_d;
    logic [IW-1:0] ipg, ipg_d;
    logic [3:0]    pid_q, pid_d;
    logic          boundary, pop_d, done_d;
    logic          bit_d, se0_d, oe_d, strobe_d, busy_d;

    wire bit_last  = (timer == TW'(CLKS_PER_BIT - 1));
    wire pre_last  = (timer == TW'(CLKS_PER_BIT - 2));
    wire stuff_due = sr[0] && (ones == 3'd5);

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            resume     <= S_IDLE;
            timer      <= '0;
            sr         <= '0;
            idx        <= '0;
            ones       <= '0;
            ipg        <= '0;
            pid_q      <= '0;
            data_pop   <= 1'b0;
            tx_bit     <= 1'b1;
            tx_se0     <= 1'b0;
            tx_oe      <= 1'b0;
            bit_strobe <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_d;
            resume     <= resume_d;
            timer      <= timer_d;
            sr         <= sr_d;
            idx        <= idx_d;
            ones       <= ones_d;
            ipg        <= ipg_d;
            pid_q      <= pid_d;
            data_pop   <= pop_d;
            tx_bit     <= bit_d;
            tx_se0     <= se0_d;
            tx_oe      <= oe_d;
            bit_strobe <= strobe_d;
            tx_busy    <= busy_d;
            tx_done    <= done_d;
        end
    end

    always_comb begin
        state_d  = state;
        resume_d = resume;
        sr_d     = sr;
        idx_d    = idx;
        ones_d   = ones;
        ipg_d    = ipg;
        pid_d    = pid_q;
        timer_d  = (state == S_IDLE || bit_last) ? '0 : timer + TW'(1);
        boundary = 1'b0;
        bnd_from = state;
        pop_d    = 1'b0;
        done_d   = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_start && !tx_done) begin
                    state_d = S_SYNC;
                    pid_d   = tx_pid;
                    sr_d    = 8'h80;
                    idx_d   = '0;
                    ones_d  = '0;
                    timer_d = '0;
                end
            end
            S_SYNC, S_PID, S_DATA: begin
                // The pop decision is made one cycle early so data_pop can be a
                // register that is high on the boundary cycle itself.
                if (pre_last && idx == 3'd7 && !stuff_due && state != S_SYNC)
                    pop_d = tx_data_valid;
                if (bit_last) begin
                    ones_d = sr[0] ? ones + 3'd1 : 3'd0;
                    if (stuff_due) begin
                        state_d  = S_STUFF;
                        resume_d = state;
                        ones_d   = '0;
                        sr_d     = sr >> 1;
                        idx_d    = idx + 3'd1;
                    end else if (idx == 3'd7) begin
                        boundary = 1'b1;
                    end else begin
                        sr_d  = sr >> 1;
                        idx_d = idx + 3'd1;
                    end
                end
            end
            S_STUFF: begin
                // idx wrapped to 0 means the stuffed bit followed bit 7.
                if (pre_last && idx == 3'd0 && resume != S_SYNC)
                    pop_d = tx_data_valid;
                if (bit_last) begin
                    if (idx == 3'd0) begin
                        boundary = 1'b1;
                        bnd_from = resume;
                    end else begin
                        state_d = resume;
                    end
                end
            end
            S_EOP_SE0: begin
                if (bit_last) begin
                    if (idx == 3'd1) begin
                        state_d = S_EOP_J;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end
            end
            S_EOP_J: begin
                if (bit_last) begin
                    state_d = S_IPG;
                    ipg_d   = '0;
                end
            end
            S_IPG: begin
                if (bit_last) begin
                    if (ipg == IW'(IPG_BITS - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ipg_d = ipg + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (boundary) begin
            idx_d = '0;
            if (bnd_from == S_SYNC) begin
                state_d = S_PID;
                sr_d    = {~pid_q, pid_q};
            end else if (data_pop) begin
                state_d = S_DATA;
                sr_d    = tx_data;
            end else begin
                state_d = S_EOP_SE0;
            end
        end
    end

    always_comb begin
        oe_d = (state_d != S_IDLE) && (state_d != S_IPG);
        case (state_d)
            S_SYNC, S_PID, S_DATA: bit_d = sr_d[0];
            S_STUFF, S_EOP_SE0:    bit_d = 1'b0;
            default:               bit_d = 1'b1;
        endcase
        se0_d    = (state_d == S_EOP_SE0);
        strobe_d = oe_d && (timer_d == '0);
        busy_d   = (state_d != S_IDLE) || done_d;
    end

endmodule

// File: doc/tx_packet_ctrl.md
# tx_packet_ctrl

Transmit packet sequencer for the CDL USB full-speed transmit path. It owns the per-bit timing counter and serialises each packet in order: SYNC, PID, zero or more data bytes from an upstream byte source, EOP and an inter-packet gap. It also performs bit stuffing. Its NRZ bit stream and SE0 indication feed the downstream NRZI encoder and line driver.

## Interface
- `CLKS_PER_BIT`, 8: clock cycles per USB bit period; legal range ≥ 2.
- `IPG_BITS`, 2: idle bit periods after EOP before the packet is reported done; legal range ≥ 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_start`  in  1  one-cycle request to send a packet; sampled only in IDLE.
- `tx_pid`  in  4  PID nibble, captured on the accepted `tx_start`; PID byte sent is {~pid, pid}.
- `tx_data`  in  8  next payload byte, valid while `tx_data_valid` is 1.
- `tx_data_valid`  in  1  a payload byte is available; 0 at a byte boundary ends the payload.
- `data_pop`  out  1  one-cycle pulse; `tx_data` is consumed this cycle.
- `tx_bit`  out  1  NRZ bit for the current bit period; 1 (J) when not driving data.
- `tx_se0`  out  1  SE0 drive during EOP.
- `tx_oe`  out  1  line output enable.
- `bit_strobe`  out  1  high on the first cycle of every bit period while `tx_oe` is 1.
- `tx_busy`  out  1  packet in progress.
- `tx_done`  out  1  one-cycle pulse at packet completion.

## Operation
- FSM states: IDLE, SYNC, PID, DATA, STUFF, EOP_SE0, EOP_J, IPG.
- IDLE → SYNC on `tx_start`. Capture `tx_pid`. Clear the bit timer, bit index and ones counter.
- SYNC shifts 0x80 LSB-first: bits 0,0,0,0,0,0,0,1.
- PID shifts {~pid, pid} LSB-first.
- DATA shifts the loaded byte LSB-first.
- Byte boundary (last cycle of bit 7 of PID or DATA, stuffing resolved):
  - If `tx_data_valid`=1: load `tx_data`, pulse `data_pop`, go to DATA.
  - Otherwise go to EOP_SE0.
- Bit stuffing:
  - The ones counter counts consecutive 1s sent in SYNC, PID and DATA, and resets on any transmitted 0.
  - When the count reaches 6, the next bit period is STUFF. STUFF sends `tx_bit`=0, does not advance the shift register or bit index, and resets the counter.
  - A stuff bit required after the final data bit is sent before EOP.
  - The byte-boundary decision is deferred until after a pending stuff bit.
- EOP_SE0 lasts 2 bit periods: `tx_se0`=1, `tx_bit`=0.
- EOP_J lasts 1 bit period: `tx_se0`=0, `tx_bit`=1.
- IPG lasts `IPG_BITS` bit periods: `tx_oe`=0, `tx_bit`=1, no `bit_strobe`. After the last period: pulse `tx_done` and return to IDLE.
- `tx_start` outside IDLE is ignored. `tx_pid` is not re-sampled mid-packet.
- `tx_data_valid` is sampled only at byte boundaries.

## Timing
- Reset values: state IDLE; `tx_bit`=1; `tx_se0`=0; `tx_oe`=0; `bit_strobe`=0; `tx_busy`=0; `tx_done`=0; `data_pop`=0. Counters are 0.
- Reset is effective on any cycle, including mid-packet. It aborts the packet with no `tx_done` and no `data_pop`. The line returns to idle J with `tx_oe`=0 in the cycle after reset is sampled.
- Bit timer width is $clog2(`CLKS_PER_BIT`). It counts 0..`CLKS_PER_BIT`−1 and wraps to 0 at each bit boundary.
- `tx_start` sampled at cycle T: cycle T+1 is cycle 0 of SYNC bit 0, with `tx_oe`=1, `bit_strobe`=1 and `tx_busy`=1.
- All outputs are registered and stable for the whole bit period.
- `data_pop` is asserted on the last cycle of the preceding bit period. The new byte's bit 0 appears on the next cycle.
- Packet length in cycles, counted from SYNC cycle 0: (8 + 8 + 8·N + stuffs + 3 + `IPG_BITS`)·`CLKS_PER_BIT`. `tx_done` is asserted on exactly that cycle index.
- `tx_busy`:
  - High from T+1 through the `tx_done` cycle inclusive.
  - Low on the following cycle.
  - A new `tx_start` is accepted on that following cycle.

## Test plan
- Reset values: hold `rst` 3 cycles → every output at its reset value. Then `tx_start`=0 for 20 cycles → outputs unchanged.
- ACK, no data (`tx_pid`=4'h2, `tx_data_valid`=0, defaults):
  - `tx_bit` per period is 0,0,0,0,0,0,0,1 | 0,1,0,0,1,0,1,1.
  - Then SE0 for 16 cycles, J for 8, `tx_oe`=0 for 16.
  - `tx_done` at cycle 168; `data_pop` never asserted.
- DATA0 with one byte 0xFF (`tx_pid`=4'h3):
  - A stuffed 0 appears after data bit 3. The data field is 1,1,1,1,0,1,1,1,1.
  - Exactly one `data_pop`, on cycle 127. `tx_done` at cycle 240.
- Two data bytes 0x00, 0xA5 → `data_pop` at cycles 127 and 191, no stuff bits, `tx_done` at cycle 296.
- `tx_start` pulsed at cycles 5 and 60 of a packet → ignored; the packet is unchanged and produces one `tx_done`.
- `rst` asserted in DATA bit 4 → the next cycle is IDLE with reset values and no `tx_done`. A `tx_start` two cycles later sends a full clean packet.
